// File: rtl/lhs.sv
// Left-hand operand pre-processor for the ALU: pass, shift left/right through
// carry, or zero, with the result and carry captured on clk when alu_clk is high.
module lhs #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             alu_clk,
    input  logic [1:0]       operation,
    input  logic [WIDTH-1:0] in,
    input  logic             carry_in,
    output logic [WIDTH-1:0] out,
    output logic             carry_out
);

    logic [WIDTH-1:0] next_out;
    logic             next_carry;

    always_comb begin
        next_out   = '0;
        next_carry = 1'b0;
        case (operation)
            2'b00: begin
                next_out   = in;
                next_carry = carry_in;
            end
            2'b01: begin
                next_out   = {in[WIDTH-2:0], carry_in};
                next_carry = in[WIDTH-1];
            end
            2'b10: begin
                next_out   = {carry_in, in[WIDTH-1:1]};
                next_carry = in[0];
            end
            default: begin
                next_out   = '0;
                next_carry = 1'b0;
            end
        endcase
    end

    // alu_clk is only a capture enable; reset wins over it
    always_ff @(posedge clk) begin
        if (!reset) begin
            out       <= '0;
            carry_out <= 1'b0;
        end else if (alu_clk) begin
            out       <= next_out;
            carry_out <= next_carry;
        end
    end

endmodule

// File: tb/tb_lhs.sv
// Scoreboard bench for lhs: stimulus pushes model predictions, a monitor pops
// and compares them one time unit after each rising clk edge.
module tb_lhs;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         alu_clk;
    logic [1:0]   operation;
    logic [W-1:0] in;
    logic         carry_in;
    logic [W-1:0] out;
    logic         carry_out;

    logic [W:0]   exp_q[$];
    logic [W-1:0] model_out = '0;
    logic         model_carry = 1'b0;
    int           checks = 0;
    int           errors = 0;
    logic         stim_done = 1'b0;

    lhs #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .alu_clk   (alu_clk),
        .operation (operation),
        .in        (in),
        .carry_in  (carry_in),
        .out       (out),
        .carry_out (carry_out)
    );

    always #5 clk = ~clk;

    // Reference: operations expressed as integer arithmetic on the operand value
    task automatic applyStimulus(input logic rst, input logic ac, input logic [1:0] op,
                                 input logic [W-1:0] d, input logic ci);
        int v;
        int half;
        int full;
        @(negedge clk);
        reset     = rst;
        alu_clk   = ac;
        operation = op;
        in        = d;
        carry_in  = ci;
        v    = int'(d);
        full = 1 << W;
        half = 1 << (W - 1);
        if (!rst) begin
            model_out   = '0;
            model_carry = 1'b0;
        end else if (ac) begin
            case (op)
                2'd0: begin
                    model_out   = W'(v);
                    model_carry = ci;
                end
                2'd1: begin
                    model_out   = W'((v * 2) % full + (ci ? 1 : 0));
                    model_carry = (v >= half);
                end
                2'd2: begin
                    model_out   = W'(v / 2 + (ci ? half : 0));
                    model_carry = (v % 2) == 1;
                end
                default: begin
                    model_out   = '0;
                    model_carry = 1'b0;
                end
            endcase
        end
        exp_q.push_back({model_carry, model_out});
    endtask

    task automatic checkOutput(input logic [W:0] expected);
        checks++;
        if (out !== expected[W-1:0] || carry_out !== expected[W]) begin
            errors++;
            $display("[TB] FAIL result check %0d: got out=0x%0h carry=%0b, expected out=0x%0h carry=%0b",
                     checks, out, carry_out, expected[W-1:0], expected[W]);
        end
    endtask

    initial begin : monitor
        logic [W:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin : stimulus
        reset = 1'b0; alu_clk = 1'b0; operation = 2'b00; in = '0; carry_in = 1'b0;
        applyStimulus(1'b0, 1'b0, 2'b00, 8'h00, 1'b0);
        applyStimulus(1'b0, 1'b0, 2'b00, 8'h00, 1'b0);
        applyStimulus(1'b1, 1'b1, 2'b00, 8'hFF, 1'b0);
        applyStimulus(1'b1, 1'b1, 2'b10, 8'hAA, 1'b0);
        applyStimulus(1'b1, 1'b1, 2'b10, 8'h55, 1'b1);
        applyStimulus(1'b1, 1'b1, 2'b01, 8'hAA, 1'b0);
        applyStimulus(1'b1, 1'b1, 2'b01, 8'h55, 1'b1);
        applyStimulus(1'b1, 1'b1, 2'b11, 8'h55, 1'b1);
        applyStimulus(1'b1, 1'b1, 2'b00, 8'h3C, 1'b1);
        applyStimulus(1'b1, 1'b0, 2'b01, 8'h81, 1'b0);
        applyStimulus(1'b1, 1'b0, 2'b10, 8'h7E, 1'b1);
        applyStimulus(1'b1, 1'b0, 2'b11, 8'hFF, 1'b1);
        applyStimulus(1'b1, 1'b1, 2'b10, 8'h7E, 1'b1);
        applyStimulus(1'b0, 1'b1, 2'b00, 8'hFF, 1'b1);
        applyStimulus(1'b1, 1'b0, 2'b00, 8'hFF, 1'b1);
        applyStimulus(1'b1, 1'b1, 2'b01, 8'h80, 1'b1);
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 19) != 0), ($urandom_range(0, 9) < 7),
                          2'($urandom_range(0, 3)), W'($urandom), 1'($urandom));
        end
        stim_done = 1'b1;
    end

    initial begin : finisher
        wait (stim_done);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain: %0d predictions left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #100000;
        errors++;
        $display("[TB] FAIL timeout: simulation time exceeded 100000, expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lhs.md
Name: lhs

Overview:
- Left-hand-side operand pre-processor of the ALU. Each ALU cycle it passes through, shifts left, shifts right (each through carry), or zeroes the WIDTH-bit operand.
- Result and carry are registered for the ALU core.
- Runs in the system clock domain. alu_clk acts as a synchronous capture enable, not a separate clock.

Parameters:
- WIDTH, 8, bus width of operand in bits; legal values >= 2.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset).
- alu_clk  input  1  ALU phase strobe, sampled on clk; high = capture enabled.
- operation  input  2  operation select (encoding below).
- in  input  WIDTH  operand.
- carry_in  input  1  carry/rotate-in bit.
- out  output  WIDTH  registered result.
- carry_out  output  1  registered carry result.

Behaviour:
- One clock (clk); reset is synchronous and active-low. No logic is clocked by alu_clk; it is an ordinary synchronous input.
- Reset:
  - On a clk rising edge with reset == 0: out <= 0 and carry_out <= 0.
  - Reset has priority over alu_clk.
- Capture:
  - On a clk rising edge with reset == 1 and alu_clk == 1: out and carry_out load the combinational result of the current operation, in and carry_in.
  - With alu_clk == 0, both outputs hold.
- Latency: one clk edge. A result is visible immediately after the first clk rising edge at which alu_clk is high with the new inputs stable. While alu_clk stays high, outputs re-track input changes on every clk edge.
- operation 2'b00, pass: out = in; carry_out = carry_in.
- operation 2'b01, shift left through carry: out = {in[WIDTH-2:0], carry_in}; carry_out = in[WIDTH-1].
- operation 2'b10, shift right through carry: out = {carry_in, in[WIDTH-1:1]}; carry_out = in[0].
- operation 2'b11, zero: out = 0; carry_out = 0; in and carry_in are ignored.
- Bit-level rules: no arithmetic, no sign extension. Exactly one bit enters and one bit leaves per shift.
- Unknown/X operation: no requirement beyond the four encodings; the decoder is a full case, so no latch is inferred.
- Reset mid-operation: outputs are cleared on that edge regardless of alu_clk. Normal capture resumes on the first edge with reset == 1 and alu_clk == 1.
- Outputs are driven only by flops; there is no combinational path from inputs to outputs.

Test Plan:
- Reset/pass:
  - Hold reset=0 for 2 clk edges -> out=0x00, carry_out=0.
  - Release reset; op=00, in=0xFF, cin=0, alu_clk pulsed high -> out=0xFF, carry_out=0.
- Shift right, no carry: op=10, in=0xAA, cin=0, alu_clk high -> out=0x55, carry_out=0. Same op with in=0x55, cin=1 -> out=0xAA, carry_out=1.
- Shift left: op=01, in=0xAA, cin=0 -> out=0x54, carry_out=1. Same op with in=0x55, cin=1 -> out=0xAB, carry_out=0.
- Zero: op=11, in=0x55, cin=1 -> out=0x00, carry_out=0.
- Hold: after a capture, change in/op while alu_clk=0 for several clk edges -> outputs unchanged. Raise alu_clk -> new result after the next clk edge.
- Reset priority: assert reset=0 with alu_clk=1 and op=00, in=0xFF -> out=0x00, carry_out=0 on that edge.
